// File: rtl/ifft8_pkg.sv
// Shared constants and types for the 8-point inverse FFT.
package ifft8_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 8;
    localparam int TW_W      = 16;

    // W^-k = cos + j*sin(2*pi*k/8) in Q8.8, indexed by k = 0..3.
    localparam logic [3:0][TW_W-1:0] TW_RE = {16'hFF4B, 16'h0000, 16'h00B5, 16'h0100};
    localparam logic [3:0][TW_W-1:0] TW_IM = {16'h00B5, 16'h0100, 16'h00B5, 16'h0000};

    // Input i lands in mem[BITREV[i]] so the in-place stages finish in natural order.
    localparam logic [7:0][2:0] BITREV = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ifft8_if.sv
// Parallel load / result bus between a producer and the ifft8 core.
interface ifft8_if #(parameter int WIDTH = 16);
    logic                        write;
    logic                        start;
    logic [7:0][WIDTH-1:0]       input_real;
    logic [7:0][WIDTH-1:0]       input_imag;
    logic [7:0][WIDTH-1:0]       output_real;
    logic [7:0][WIDTH-1:0]       output_imag;
    logic                        ready;

    modport master (
        output write, start, input_real, input_imag,
        input  output_real, output_imag, ready
    );
    modport slave (
        input  write, start, input_real, input_imag,
        output output_real, output_imag, ready
    );
endinterface

// File: rtl/ifft8_butterfly.sv
// Combinational radix-2 butterfly with twiddle multiply, halving and saturation.
module ifft8_butterfly
    import ifft8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic        [1:0]       k,
    output logic signed [WIDTH-1:0] top_re,
    output logic signed [WIDTH-1:0] top_im,
    output logic signed [WIDTH-1:0] bot_re,
    output logic signed [WIDTH-1:0] bot_im
);
    // Product width holds a full complex product sum; SW holds a +/- t without overflow.
    localparam int PW = WIDTH + TW_W + 1;
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

    logic        [TW_W-1:0] w_re_u, w_im_u;
    logic signed [PW-1:0]   br_x, bi_x, wr_x, wi_x, pr, pi, sr, si;
    logic signed [SW-1:0]   t_re, t_im, ar_x, ai_x;
    logic signed [SW-1:0]   s_re, s_im, d_re, d_im;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > MAXV)      return MAXV[WIDTH-1:0];
        else if (v < MINV) return MINV[WIDTH-1:0];
        else               return v[WIDTH-1:0];
    endfunction

    // t = b*W with floor shift, then halved sum/difference saturated to WIDTH.
    always_comb begin
        w_re_u = TW_RE[k];
        w_im_u = TW_IM[k];
        br_x   = {{(PW-WIDTH){b_re[WIDTH-1]}}, b_re};
        bi_x   = {{(PW-WIDTH){b_im[WIDTH-1]}}, b_im};
        wr_x   = {{(PW-TW_W){w_re_u[TW_W-1]}}, w_re_u};
        wi_x   = {{(PW-TW_W){w_im_u[TW_W-1]}}, w_im_u};
        pr     = br_x * wr_x - bi_x * wi_x;
        pi     = br_x * wi_x + bi_x * wr_x;
        sr     = pr >>> FRAC;
        si     = pi >>> FRAC;
        t_re   = sr[SW-1:0];
        t_im   = si[SW-1:0];
        ar_x   = {{2{a_re[WIDTH-1]}}, a_re};
        ai_x   = {{2{a_im[WIDTH-1]}}, a_im};
        s_re   = (ar_x + t_re) >>> 1;
        s_im   = (ai_x + t_im) >>> 1;
        d_re   = (ar_x - t_re) >>> 1;
        d_im   = (ai_x - t_im) >>> 1;
        top_re = sat(s_re);
        top_im = sat(s_im);
        bot_re = sat(d_re);
        bot_im = sat(d_im);
    end
endmodule

// File: rtl/ifft8.sv
// Iterative 8-point inverse FFT: one shared butterfly, 12 butterflies per transform.
module ifft8
    import ifft8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic    clk,
    input  logic    rst,
    ifft8_if.slave  bus
);
    state_t                  state, state_nx;
    logic [3:0]              c;
    logic signed [WIDTH-1:0] mem_re [8];
    logic signed [WIDTH-1:0] mem_im [8];
    logic [2:0]              top_a, bot_a;
    logic [1:0]              tw_k, j;
    logic                    load;
    logic signed [WIDTH-1:0] top_re, top_im, bot_re, bot_im;

    assign j    = c[1:0];
    assign load = bus.write && (state != RUN);

    // Address/twiddle generation: stage c/4, butterfly c%4, span 1<<stage.
    always_comb begin
        top_a = {j, 1'b0};
        bot_a = {j, 1'b1};
        tw_k  = 2'd0;
        case (c[3:2])
            2'd0: begin
                top_a = {j, 1'b0};
                bot_a = {j, 1'b1};
                tw_k  = 2'd0;
            end
            2'd1: begin
                top_a = {j[1], 1'b0, j[0]};
                bot_a = {j[1], 1'b1, j[0]};
                tw_k  = {j[0], 1'b0};
            end
            default: begin
                top_a = {1'b0, j};
                bot_a = {1'b1, j};
                tw_k  = j;
            end
        endcase
    end

    ifft8_butterfly #(.WIDTH(WIDTH), .FRAC(FRAC)) u_bfly (
        .a_re   (mem_re[top_a]),
        .a_im   (mem_im[top_a]),
        .b_re   (mem_re[bot_a]),
        .b_im   (mem_im[bot_a]),
        .k      (tw_k),
        .top_re (top_re),
        .top_im (top_im),
        .bot_re (bot_re),
        .bot_im (bot_im)
    );

    // Next-state logic; write/start are ignored while running, start alone ignored in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN:  if (c == 4'd11) state_nx = DONE;
            DONE: begin
                if (bus.write && bus.start) state_nx = RUN;
                else if (bus.write)         state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, butterfly counter and in-place register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            c     <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == RUN) c <= (c == 4'd11) ? 4'd0 : c + 4'd1;
            else              c <= 4'd0;
            if (load) begin
                for (int i = 0; i < 8; i++) begin
                    mem_re[BITREV[i]] <= $signed(bus.input_real[i]);
                    mem_im[BITREV[i]] <= $signed(bus.input_imag[i]);
                end
            end else if (state == RUN) begin
                mem_re[top_a] <= top_re;
                mem_im[top_a] <= top_im;
                mem_re[bot_a] <= bot_re;
                mem_im[bot_a] <= bot_im;
            end
        end
    end

    // Results come straight from the register file.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bus.output_real[i] = mem_re[i];
            bus.output_imag[i] = mem_im[i];
        end
        bus.ready = (state == DONE);
    end
endmodule
